// File: rtl/seven_segment_scanner_pkg.sv
// ---------------------------------------------------------------------------
// seven_segment_scanner_pkg
//
// Shared definitions for the seven-segment scan driver:
//   - default geometry and timing (digit count, slot length, guard length)
//   - the all-anodes-off pattern, sized for the largest legal display
//   - a small nibble helper used by the leading-zero logic
//
// Users slice SSD_ANODE_OFF down to their own digit count, so one constant
// serves every legal NUM_DIGITS (2..8).
// ---------------------------------------------------------------------------
package seven_segment_scanner_pkg;

  // Default geometry / timing.
  localparam int SSD_NUM_DIGITS  = 4;
  localparam int SSD_REFRESH_DIV = 50000;
  localparam int SSD_GUARD       = 1;
  localparam int SSD_DIV_W       = 16;

  // Largest display this block is meant to scan.
  localparam int SSD_MAX_DIGITS  = 8;

  typedef logic [SSD_MAX_DIGITS-1:0] anode_vec_t;
  typedef logic [3:0]                nibble_t;

  // Anodes are active-low, so "all off" is all ones.
  localparam anode_vec_t SSD_ANODE_OFF = '1;

  // True when a digit holds the value zero.
  function automatic logic nibble_is_zero(input nibble_t n);
    return (n == 4'h0);
  endfunction

endpackage : seven_segment_scanner_pkg

// File: rtl/seven_segment_scanner_refresh_counter.sv
// ---------------------------------------------------------------------------
// seven_segment_scanner_refresh_counter
//
// Scan timebase for the seven-segment scanner. Divides clk into digit slots
// of REFRESH_DIV cycles and steps the digit index once per slot, so a full
// frame is NUM_DIGITS * REFRESH_DIV cycles.
//
// Ports
//   clk         in   1       system clock
//   reset       in   1       synchronous, active-high
//   digit_idx   out  IDX_W   digit currently being scanned (0 = LSD)
//   guard       out  1       first GUARD cycles of a slot (anodes must be off)
//   frame_tick  out  1       last cycle of the last slot of a frame
//
// All outputs are decoded from the counter registers only (Moore).
// ---------------------------------------------------------------------------
module seven_segment_scanner_refresh_counter
  import seven_segment_scanner_pkg::*;
#(
  parameter int NUM_DIGITS  = SSD_NUM_DIGITS,
  parameter int REFRESH_DIV = SSD_REFRESH_DIV,
  parameter int GUARD       = SSD_GUARD,
  parameter int DIV_W       = SSD_DIV_W
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          guard,
  output logic                          frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [DIV_W-1:0] LAST_CNT = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             slot_end;

  assign slot_end   = (div_cnt == LAST_CNT);
  assign frame_tick = slot_end && (digit_idx == LAST_IDX);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt   <= '0;
      digit_idx <= '0;
    end else if (slot_end) begin
      div_cnt   <= '0;
      digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
    end else begin
      div_cnt   <= div_cnt + 1'b1;
    end
  end

  // With no guard the comparison would be constant-false; tie it off instead.
  generate
    if (GUARD == 0) begin : g_no_guard
      assign guard = 1'b0;
    end else begin : g_guard
      assign guard = (div_cnt < DIV_W'(GUARD));
    end
  endgenerate

endmodule : seven_segment_scanner_refresh_counter

// File: rtl/seven_segment_scanner.sv
// ---------------------------------------------------------------------------
// seven_segment_scanner
//
// Time-multiplexed scan driver for a common-anode multi-digit 7-segment
// display. Sits directly upstream of the segment decoder (which the parent
// instantiates). A frame-synchronous copy of the displayed value is held so
// that a frame never mixes old and new digits: loads are parked in a pending
// register and promoted to the active register on the last cycle of a frame.
//
// Ports
//   clk          in   1              system clock
//   reset        in   1              synchronous, active-high
//   load         in   1              strobe: capture value_in / dp_in
//   value_in     in   4*NUM_DIGITS   packed nibbles, [3:0] = digit 0
//   dp_in        in   NUM_DIGITS     decimal point per digit, 1 = lit
//   blank_lz     in   1              1 = suppress leading zeros (level)
//   nibble_out   out  4              nibble of the scanned digit, to decoder
//   digit_en_n   out  NUM_DIGITS     anode enables, active-low, one-cold
//   dp_out       out  1              decimal point of the scanned digit
//   blank        out  1              1 = scanned digit suppressed
//   frame_tick   out  1              pulse on last cycle of a frame
//   update_pend  out  1              1 = a load is waiting for the frame end
//
// Outputs are decoded from registered state (plus the blank_lz level); while
// reset is high they are forced to the idle pattern.
// ---------------------------------------------------------------------------
module seven_segment_scanner
  import seven_segment_scanner_pkg::*;
#(
  parameter int NUM_DIGITS  = SSD_NUM_DIGITS,
  parameter int REFRESH_DIV = SSD_REFRESH_DIV,
  parameter int GUARD       = SSD_GUARD,
  parameter int DIV_W       = SSD_DIV_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [3:0]              nibble_out,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic                    dp_out,
  output logic                    blank,
  output logic                    frame_tick,
  output logic                    update_pend
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = SSD_ANODE_OFF[NUM_DIGITS-1:0];

  // -------------------------------------------------------------------------
  // Scan timebase
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0] digit_idx;
  logic             guard;
  logic             tick_raw;

  seven_segment_scanner_refresh_counter #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .GUARD       (GUARD),
    .DIV_W       (DIV_W)
  ) u_refresh_counter (
    .clk        (clk),
    .reset      (reset),
    .digit_idx  (digit_idx),
    .guard      (guard),
    .frame_tick (tick_raw)
  );

  // -------------------------------------------------------------------------
  // Pending / active value registers
  // -------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [4*NUM_DIGITS-1:0] active_val;
  logic [NUM_DIGITS-1:0]   active_dp;

  // A load coinciding with the frame tick bypasses the pending register and
  // goes straight to active, so it is never left stranded for a whole frame.
  // Any other load simply overwrites the pending copy (last one wins).
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_val    <= '0;
      pend_dp     <= '0;
      active_val  <= '0;
      active_dp   <= '0;
      update_pend <= 1'b0;
    end else if (tick_raw) begin
      if (load) begin
        active_val <= value_in;
        active_dp  <= dp_in;
      end else if (update_pend) begin
        active_val <= pend_val;
        active_dp  <= pend_dp;
      end
      update_pend <= 1'b0;
    end else if (load) begin
      pend_val    <= value_in;
      pend_dp     <= dp_in;
      update_pend <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Leading-zero detection
  // upper_zero[i] = nibbles i..NUM_DIGITS-1 of the active value are all zero.
  // Built by sweeping down from the most significant digit.
  // -------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] upper_zero;
  logic                  zero_run;
  logic                  lz_blank;

  // NOTE: every signal assigned in an always_comb gets a default before any
  // conditional logic, otherwise a missed path would infer a latch.
  always_comb begin
    upper_zero = '0;
    zero_run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run & nibble_is_zero(active_val[4*i +: 4]);
      upper_zero[i] = zero_run;
    end
  end

  // Digit 0 always shows, so a value of zero still displays a single "0".
  assign lz_blank = blank_lz && (digit_idx != '0) && upper_zero[digit_idx];

  // -------------------------------------------------------------------------
  // Output mux
  // -------------------------------------------------------------------------
  always_comb begin
    nibble_out = '0;
    dp_out     = 1'b0;
    blank      = 1'b1;
    frame_tick = 1'b0;
    digit_en_n = ANODE_OFF;
    if (!reset) begin
      nibble_out = active_val[{digit_idx, 2'b00} +: 4];
      blank      = lz_blank;
      frame_tick = tick_raw;
      dp_out     = active_dp[digit_idx] && !guard && !lz_blank;
      if (!guard && !lz_blank) begin
        digit_en_n = ~(NUM_DIGITS'(1) << digit_idx);
      end
    end
  end

endmodule : seven_segment_scanner

// File: tb/tb_seven_segment_scanner.sv
// ---------------------------------------------------------------------------
// tb_seven_segment_scanner
//
// Directed scenarios followed by a randomized phase. The reference model
// tracks the number of cycles since reset and derives slot, digit and frame
// position from it arithmetically; displayed digits are read out of the
// model's value by shifting. Every cycle all outputs are compared.
// ---------------------------------------------------------------------------
module tb_seven_segment_scanner;

  localparam int N     = 4;
  localparam int R     = 4;
  localparam int G     = 1;
  localparam int DW    = 3;
  localparam int FRAME = N * R;

  logic           clk = 1'b0;
  logic           reset;
  logic           load;
  logic [4*N-1:0] value_in;
  logic [N-1:0]   dp_in;
  logic           blank_lz;
  logic [3:0]     nibble_out;
  logic [N-1:0]   digit_en_n;
  logic           dp_out;
  logic           blank;
  logic           frame_tick;
  logic           update_pend;

  seven_segment_scanner #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (R),
    .GUARD       (G),
    .DIV_W       (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .value_in    (value_in),
    .dp_in       (dp_in),
    .blank_lz    (blank_lz),
    .nibble_out  (nibble_out),
    .digit_en_n  (digit_en_n),
    .dp_out      (dp_out),
    .blank       (blank),
    .frame_tick  (frame_tick),
    .update_pend (update_pend)
  );

  always #5 clk = ~clk;

  // Reference model state.
  int             cycle;
  bit             m_known;
  logic [4*N-1:0] m_active;
  logic [N-1:0]   m_dp;
  logic [4*N-1:0] m_pval;
  logic [N-1:0]   m_pdp;
  bit             m_pend;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cycle);
    end
  endtask

  // Compare every output against what the model says the current cycle shows.
  task automatic check_outputs();
    int         digit, pos;
    bit         grd, lz;
    logic [3:0] e_nib;
    logic [N-1:0] e_en;
    logic       e_dp;
    if (m_known) check("update_pend", 32'(update_pend), 32'(m_pend));
    if (reset) begin
      check("rst_en",    32'(digit_en_n), 32'hF);
      check("rst_nib",   32'(nibble_out), 32'h0);
      check("rst_dp",    32'(dp_out),     32'h0);
      check("rst_blank", 32'(blank),      32'h1);
      check("rst_tick",  32'(frame_tick), 32'h0);
    end else begin
      digit = (cycle / R) % N;
      pos   = cycle % R;
      grd   = (pos < G);
      lz    = blank_lz && (digit != 0) && ((m_active >> (4 * digit)) == 0);
      e_nib = 4'(m_active >> (4 * digit));
      e_en  = (grd || lz) ? 4'hF : 4'(~(4'b0001 << digit));
      e_dp  = m_dp[digit] && !grd && !lz;
      check("nibble", 32'(nibble_out), 32'(e_nib));
      check("en",     32'(digit_en_n), 32'(e_en));
      check("dp",     32'(dp_out),     32'(e_dp));
      check("blank",  32'(blank),      32'(lz));
      check("tick",   32'(frame_tick), 32'((cycle % FRAME) == FRAME - 1));
    end
  endtask

  // One clock: check current outputs, advance model on the edge, return at
  // the following falling edge where new inputs may be driven.
  task automatic cyc();
    bit tick;
    #1;
    check_outputs();
    @(posedge clk);
    if (reset) begin
      cycle    = 0;
      m_known  = 1'b1;
      m_active = '0; m_dp = '0; m_pval = '0; m_pdp = '0; m_pend = 1'b0;
    end else begin
      tick = ((cycle % FRAME) == FRAME - 1);
      if (tick) begin
        if (load) begin
          m_active = value_in; m_dp = dp_in;
        end else if (m_pend) begin
          m_active = m_pval; m_dp = m_pdp;
        end
        m_pend = 1'b0;
      end else if (load) begin
        m_pval = value_in; m_pdp = dp_in; m_pend = 1'b1;
      end
      cycle++;
    end
    @(negedge clk);
  endtask

  task automatic run_to(input int target);
    int budget = 200;
    while (cycle < target && budget > 0) begin
      cyc();
      budget--;
    end
  endtask

  task automatic do_load(input logic [4*N-1:0] v, input logic [N-1:0] d);
    value_in = v; dp_in = d; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    cycle = 0; m_known = 1'b0;
    m_active = '0; m_dp = '0; m_pval = '0; m_pdp = '0; m_pend = 1'b0;
    reset = 1'b1; load = 1'b0; value_in = '0; dp_in = '0; blank_lz = 1'b0;
    cyc(); cyc();
    reset = 1'b0;

    // 1: load at cycle 2, visible from frame 2.
    run_to(2);
    do_load(16'h12AF, 4'b0000);
    run_to(15); #1;
    check("s1_tick15", 32'(frame_tick), 32'h1);
    check("s1_pend15", 32'(update_pend), 32'h1);
    run_to(16); #1;
    check("s1_c16_en", 32'(digit_en_n), 32'hF);
    cyc(); #1;
    check("s1_c17_en",  32'(digit_en_n), 32'hE);
    check("s1_c17_nib", 32'(nibble_out), 32'hF);
    run_to(29); #1;
    check("s1_d3_nib", 32'(nibble_out), 32'h1);
    check("s1_d3_en",  32'(digit_en_n), 32'h7);
    run_to(31); #1;
    check("s1_tick31", 32'(frame_tick), 32'h1);

    // 2: two loads in one frame, last wins at the next frame.
    run_to(33); do_load(16'h1234, 4'b0000);
    run_to(36); do_load(16'h5678, 4'b0000);
    #1;
    check("s2_pend", 32'(update_pend), 32'h1);
    run_to(37); #1;
    check("s2_old_d1", 32'(nibble_out), 32'hA);
    run_to(49); #1;
    check("s2_new_d0", 32'(nibble_out), 32'h8);
    check("s2_pend0",  32'(update_pend), 32'h0);
    run_to(61); #1;
    check("s2_new_d3", 32'(nibble_out), 32'h5);

    // 3: leading-zero suppression.
    blank_lz = 1'b1;
    run_to(66); do_load(16'h0050, 4'b0000);
    run_to(85); #1;
    check("s3_d1_nib", 32'(nibble_out), 32'h5);
    check("s3_d1_en",  32'(digit_en_n), 32'hD);
    run_to(89); #1;
    check("s3_d2_blank", 32'(blank),      32'h1);
    check("s3_d2_en",    32'(digit_en_n), 32'hF);
    run_to(93); #1;
    check("s3_d3_blank", 32'(blank), 32'h1);
    run_to(97); #1;
    check("s3_d0_en", 32'(digit_en_n), 32'hE);
    do_load(16'h0000, 4'b0000);
    run_to(113); #1;
    check("s3_z_d0_en", 32'(digit_en_n), 32'hE);
    run_to(117); #1;
    check("s3_z_d1_en", 32'(digit_en_n), 32'hF);

    // 4: load exactly on the frame tick.
    blank_lz = 1'b0;
    run_to(127); #1;
    check("s4_tick", 32'(frame_tick), 32'h1);
    do_load(16'hBEEF, 4'b0000);
    #1;
    check("s4_pend", 32'(update_pend), 32'h0);
    run_to(129); #1;
    check("s4_d0", 32'(nibble_out), 32'hF);
    run_to(141); #1;
    check("s4_d3", 32'(nibble_out), 32'hB);

    // 5: reset mid-slot with a pending update.
    run_to(146); do_load(16'h4321, 4'b1111);
    run_to(154); #1;
    check("s5_pend_pre", 32'(update_pend), 32'h1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    check("s5_en",   32'(digit_en_n), 32'hF);
    check("s5_pend", 32'(update_pend), 32'h0);
    run_to(17); #1;
    check("s5_d0", 32'(nibble_out), 32'h0);

    // 6: decimal point on digit 2 only, suppressed in guard cycles.
    run_to(22); do_load(16'h9876, 4'b0100);
    run_to(40); #1;
    check("s6_guard_dp", 32'(dp_out), 32'h0);
    cyc(); #1;
    check("s6_dp", 32'(dp_out), 32'h1);
    run_to(48);

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      load     = ($urandom_range(0, 4) == 0);
      value_in = 16'($urandom);
      dp_in    = 4'($urandom);
      if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
      cyc();
    end
    reset = 1'b0; load = 1'b0;
    repeat (FRAME) cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_seven_segment_scanner
